pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline. It keeps a shadow scoreboard of the destination registers in EX, MEM and WB, and drives four things: the forwarding selects/data into the ID/EX register (`rd1_op`/`rd1_f`, `rd2_op`/`rd2_f`), the PC and IF/ID stall, and the IF/ID and ID/EX flush. It also keeps stall and flush performance counters. It sits beside `pr_IF_ID`/ID/EX in the top-level CPU.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CNT_W`, 32, performance counter width

Ports:
- `clk`  in  1  pipeline clock
- `rst_n`  in  1  reset, synchronous, active-high (asserted = 1), per the codebase's existing `rst_n` convention
- `ID_rs1`, `ID_rs2`  in  5 each  source registers of the instruction in ID
- `ID_rs1_used`, `ID_rs2_used`  in  1 each  instruction reads that source
- `ID_rf_we`  in  1  instruction in ID writes the register file
- `ID_waddr`  in  5  destination of the instruction in ID
- `ID_wb_sel`  in  2  writeback select; `2'b01` = DRAM read (load)
- `EX_branch_taken`  in  1  branch/jump resolved taken in EX this cycle
- `EX_alu_res`  in  XLEN  ALU result in EX
- `MEM_wdata`  in  XLEN  writeback value in MEM (DRAM read data when MEM holds a load)
- `WB_wdata`  in  XLEN  writeback value in WB
- `pc_stall`, `if_id_stall`  out  1  hold PC / hold IF/ID
- `if_id_flush`, `id_ex_flush`  out  1  bubble IF/ID / bubble ID/EX at next edge
- `rd1_op`, `rd2_op`  out  1  ID/EX captures `rdX_f` instead of the register-file value
- `rd1_f`, `rd2_f`  out  XLEN  forwarded operand
- `stall_cnt`, `flush_cnt`  out  CNT_W  load-use stall cycles / branch flush events

## Operation
- Shadow stages: `ex_{we,waddr,load}`, `mem_{we,waddr,load}`, `wb_{we,waddr}`. Each clock the shadow shifts ID→EX→MEM→WB.
- The EX slot loads `ID_rf_we`, `ID_waddr` and `ID_wb_sel==2'b01`, or zeros when `id_ex_flush` is asserted.
- Match rule: a stage matches source s when its `we` is set, its `waddr == s`, and `s != 0`. Register x0 never matches.
- Load-use hazard: `luh` = the EX stage is a load and matches a used ID source.
- Forwarding priority per source is EX > MEM > WB:
  - EX match and not a load: `rdX_f = EX_alu_res`.
  - MEM match: `rdX_f = MEM_wdata`.
  - WB match: `rdX_f = WB_wdata`.
  - No match: `rdX_op = 0` and `rdX_f = 0`.
- `rdX_op` also requires `ID_rsX_used`.
- FSM states:
  - `RUN`: normal operation.
  - `STALL`: one bubble cycle inserted for a load-use hazard.
  - `FLUSH`: one cycle after a taken branch.
- FSM transitions:
  - RUN→STALL when `luh && !EX_branch_taken`.
  - Any state → FLUSH when `EX_branch_taken` (taken branch has priority).
  - STALL→RUN and FLUSH→RUN otherwise. The load is then in MEM and is forwarded from `MEM_wdata`.
- Outputs (combinational from state, shadow and inputs):
  - Branch taken: `if_id_flush = id_ex_flush = 1`, stalls = 0. A wrong-path `luh` is ignored.
  - Else `luh`: `pc_stall = if_id_stall = id_ex_flush = 1`, `if_id_flush = 0`.
  - Else: all four outputs = 0.
- Counters:
  - `stall_cnt` increments in each cycle where `luh && !EX_branch_taken`.
  - `flush_cnt` increments in each cycle where `EX_branch_taken`.
  - Both wrap modulo 2^CNT_W.

## Timing
- Forwarding, stall and flush outputs are valid in the same cycle as their inputs, with no added latency. They are registered by the consuming pipeline registers at the next edge.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs 2 flushed instructions, removed by one flush pulse that hits both registers.
- Back-to-back loads feeding each other: one stall per dependent pair. The second stall is counted separately.
- Reset (`rst_n = 1` at an edge):
  - Shadow, FSM (→RUN) and counters clear.
  - Outputs go to 0 at that edge, except that the combinational forward/stall terms see a zeroed shadow.
- Reset asserted mid-stall drops the stall at the next edge.

## Structure
- Shared `pipe_pkg` holds:
  - the FSM state enum (`RUN`, `STALL`, `FLUSH`);
  - the `WB_SEL_DRAM = 2'b01` encoding;
  - `REG_X0 = 5'd0`.
- Sub-module `fwd_sel`: one source → `op`/`data`, given the shadow stages and stage data. It is instantiated twice (rs1, rs2).

## Test plan
- `x1 = 5` in EX (ALU, `EX_alu_res = 32'h5`); ID reads `rs1 = x1` → `rd1_op = 1`, `rd1_f = 5`, no stall.
- `lw x2` in EX; ID `add` uses `rs2 = x2` → `pc_stall = if_id_stall = id_ex_flush = 1` for 1 cycle. Next cycle: `rd2_op = 1`, `rd2_f = MEM_wdata = 32'hDEAD`, and `stall_cnt = 1`.
- `EX_branch_taken = 1` while a load-use condition is also present → `if_id_flush = id_ex_flush = 1`, `pc_stall = 0`, `flush_cnt = 1`, `stall_cnt` unchanged.
- Writes to x0 in EX, MEM and WB; ID reads x0 → `rd1_op = rd2_op = 0`.
- The same register pending in EX (`EX_alu_res = 1`), MEM (`MEM_wdata = 2`) and WB (`WB_wdata = 3`) → `rd1_f = 1`. With the EX slot bubbled → `rd1_f = 2`.
- Assert `rst_n` during the STALL state → next cycle FSM = RUN, counters = 0, no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, writeback
// encodings and the scoreboard match helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] WB_SEL_DRAM = 2'b01;
    localparam logic [4:0] REG_X0      = 5'd0;

    // A pending write satisfies a source read; x0 is never forwarded.
    function automatic logic reg_hit(
        input logic       we,
        input logic [4:0] waddr,
        input logic [4:0] src
    );
        return we && (waddr == src) && (src != REG_X0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forward selector for one ID source register.
// Picks the youngest pending writer among EX, MEM and WB.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      i_src,
    input  logic            i_used,
    input  logic            i_ex_we,
    input  logic [4:0]      i_ex_waddr,
    input  logic            i_ex_load,
    input  logic            i_mem_we,
    input  logic [4:0]      i_mem_waddr,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_waddr,
    input  logic [XLEN-1:0] i_ex_data,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_op,
    output logic [XLEN-1:0] o_data
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_ex_hit  = reg_hit(i_ex_we, i_ex_waddr, i_src);
    assign w_mem_hit = reg_hit(i_mem_we, i_mem_waddr, i_src);
    assign w_wb_hit  = reg_hit(i_wb_we, i_wb_waddr, i_src);

    // Priority EX > MEM > WB; a load in EX has no data yet.
    always_comb begin
        o_op   = 1'b0;
        o_data = '0;
        if (w_ex_hit && !i_ex_load) begin
            o_op   = i_used;
            o_data = i_ex_data;
        end else if (w_mem_hit) begin
            o_op   = i_used;
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_op   = i_used;
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadow scoreboard of EX/MEM/WB
// destinations, load-use stall, branch flush and perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic             ID_rf_we,
    input  logic [4:0]       ID_waddr,
    input  logic [1:0]       ID_wb_sel,
    input  logic             EX_branch_taken,
    input  logic [XLEN-1:0]  EX_alu_res,
    input  logic [XLEN-1:0]  MEM_wdata,
    input  logic [XLEN-1:0]  WB_wdata,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             rd1_op,
    output logic             rd2_op,
    output logic [XLEN-1:0]  rd1_f,
    output logic [XLEN-1:0]  rd2_f,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic       r_ex_we;
    logic [4:0] r_ex_waddr;
    logic       r_ex_load;
    logic       r_mem_we;
    logic [4:0] r_mem_waddr;
    logic       r_wb_we;
    logic [4:0] r_wb_waddr;
    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_luh;
    logic       w_stall_ev;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_luh = r_ex_load &&
        ((ID_rs1_used && reg_hit(r_ex_we, r_ex_waddr, ID_rs1)) ||
         (ID_rs2_used && reg_hit(r_ex_we, r_ex_waddr, ID_rs2)));

    assign w_stall_ev = w_luh && !EX_branch_taken;

    // Taken branch wins; wrong-path load-use is discarded.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (EX_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_luh) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Next FSM state: flush beats stall, both last one cycle.
    always_comb begin
        w_state_nxt = RUN;
        if (EX_branch_taken) begin
            w_state_nxt = FLUSH;
        end else if (w_luh && (r_state == RUN)) begin
            w_state_nxt = STALL;
        end
    end

    // Shadow pipeline of destinations; EX takes a bubble on flush.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ex_we     <= 1'b0;
            r_ex_waddr  <= REG_X0;
            r_ex_load   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= REG_X0;
            r_wb_we     <= 1'b0;
            r_wb_waddr  <= REG_X0;
        end else begin
            if (id_ex_flush) begin
                r_ex_we    <= 1'b0;
                r_ex_waddr <= REG_X0;
                r_ex_load  <= 1'b0;
            end else begin
                r_ex_we    <= ID_rf_we;
                r_ex_waddr <= ID_waddr;
                r_ex_load  <= (ID_wb_sel == WB_SEL_DRAM);
            end
            r_mem_we    <= r_ex_we;
            r_mem_waddr <= r_ex_waddr;
            r_wb_we     <= r_mem_we;
            r_wb_waddr  <= r_mem_waddr;
        end
    end

    // Hazard FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stall-cycle and flush-event counters, wrapping.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_ev) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (EX_branch_taken) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    fwd_sel #(.XLEN(XLEN)) u_fwd1 (
        .i_src       (ID_rs1),
        .i_used      (ID_rs1_used),
        .i_ex_we     (r_ex_we),
        .i_ex_waddr  (r_ex_waddr),
        .i_ex_load   (r_ex_load),
        .i_mem_we    (r_mem_we),
        .i_mem_waddr (r_mem_waddr),
        .i_wb_we     (r_wb_we),
        .i_wb_waddr  (r_wb_waddr),
        .i_ex_data   (EX_alu_res),
        .i_mem_data  (MEM_wdata),
        .i_wb_data   (WB_wdata),
        .o_op        (rd1_op),
        .o_data      (rd1_f)
    );

    fwd_sel #(.XLEN(XLEN)) u_fwd2 (
        .i_src       (ID_rs2),
        .i_used      (ID_rs2_used),
        .i_ex_we     (r_ex_we),
        .i_ex_waddr  (r_ex_waddr),
        .i_ex_load   (r_ex_load),
        .i_mem_we    (r_mem_we),
        .i_mem_waddr (r_mem_waddr),
        .i_wb_we     (r_wb_we),
        .i_wb_waddr  (r_wb_waddr),
        .i_ex_data   (EX_alu_res),
        .i_mem_data  (MEM_wdata),
        .i_wb_data   (WB_wdata),
        .o_op        (rd2_op),
        .o_data      (rd2_f)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table driven through a
// scoreboard queue, plus reset-in-stall and counter-wrap sequences.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    typedef struct {
        string       nm;
        bit          rst;
        bit [4:0]    rs1;
        bit          u1;
        bit [4:0]    rs2;
        bit          u2;
        bit          we;
        bit [4:0]    wa;
        bit          ld;
        bit          br;
        bit [31:0]   alu;
        bit [31:0]   mem;
        bit [31:0]   wb;
        bit [3:0]    ctl;
        bit          o1;
        bit [31:0]   f1;
        bit          o2;
        bit [31:0]   f2;
        bit [7:0]    sc;
        bit [7:0]    fc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_rs1_used;
    logic        ID_rs2_used;
    logic        ID_rf_we;
    logic [4:0]  ID_waddr;
    logic [1:0]  ID_wb_sel;
    logic        EX_branch_taken;
    logic [31:0] EX_alu_res;
    logic [31:0] MEM_wdata;
    logic [31:0] WB_wdata;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        rd1_op;
    logic        rd2_op;
    logic [31:0] rd1_f;
    logic [31:0] rd2_f;
    logic [7:0]  stall_cnt;
    logic [7:0]  flush_cnt;

    int total;
    int bad;
    vec_t tbl[$];
    vec_t sb[$];

    pipe_hazard_ctrl #(.XLEN(32), .CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_rs1_used     (ID_rs1_used),
        .ID_rs2_used     (ID_rs2_used),
        .ID_rf_we        (ID_rf_we),
        .ID_waddr        (ID_waddr),
        .ID_wb_sel       (ID_wb_sel),
        .EX_branch_taken (EX_branch_taken),
        .EX_alu_res      (EX_alu_res),
        .MEM_wdata       (MEM_wdata),
        .WB_wdata        (WB_wdata),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .rd1_op          (rd1_op),
        .rd2_op          (rd2_op),
        .rd1_f           (rd1_f),
        .rd2_f           (rd2_f),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        string nm,
        bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
        bit we, bit [4:0] wa, bit ld, bit br,
        bit [31:0] alu, bit [31:0] mem, bit [31:0] wb,
        bit [3:0] ctl,
        bit o1, bit [31:0] f1, bit o2, bit [31:0] f2,
        bit [7:0] sc, bit [7:0] fc
    );
        vec_t v;
        v.nm  = nm;  v.rst = 1'b0;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.we  = we;  v.wa = wa; v.ld = ld;   v.br = br;
        v.alu = alu; v.mem = mem; v.wb = wb;
        v.ctl = ctl;
        v.o1  = o1;  v.f1 = f1; v.o2 = o2;   v.f2 = f2;
        v.sc  = sc;  v.fc = fc;
        return v;
    endfunction

    task automatic chk(string nm, string fld,
                       logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s act=%h exp=%h", nm, fld, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n           = v.rst;
        ID_rs1          = v.rs1;
        ID_rs1_used     = v.u1;
        ID_rs2          = v.rs2;
        ID_rs2_used     = v.u2;
        ID_rf_we        = v.we;
        ID_waddr        = v.wa;
        ID_wb_sel       = v.ld ? 2'b01 : 2'b00;
        EX_branch_taken = v.br;
        EX_alu_res      = v.alu;
        MEM_wdata       = v.mem;
        WB_wdata        = v.wb;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk(e.nm, "ctl",
            {28'd0, pc_stall, if_id_stall, if_id_flush, id_ex_flush},
            {28'd0, e.ctl});
        chk(e.nm, "rd1_op", {31'd0, rd1_op}, {31'd0, e.o1});
        chk(e.nm, "rd1_f", rd1_f, e.f1);
        chk(e.nm, "rd2_op", {31'd0, rd2_op}, {31'd0, e.o2});
        chk(e.nm, "rd2_f", rd2_f, e.f2);
        chk(e.nm, "stall_cnt", {24'd0, stall_cnt}, {24'd0, e.sc});
        chk(e.nm, "flush_cnt", {24'd0, flush_cnt}, {24'd0, e.fc});
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;

        tbl.push_back(mk("rst_state", 0,0,0,0, 0,0,0,0, 0,0,0, 4'b0000, 0,0,0,0, 0,0));
        tbl.push_back(mk("alu_x1",    0,0,0,0, 1,1,0,0, 0,0,0, 4'b0000, 0,0,0,0, 0,0));
        tbl.push_back(mk("fwd_ex",    1,1,0,0, 1,2,1,0, 5,0,0, 4'b0000, 1,5,0,0, 0,0));
        tbl.push_back(mk("luh",       1,1,2,1, 1,3,0,0, 7,9,0, 4'b1101, 1,9,0,0, 0,0));
        tbl.push_back(mk("ld_fwd_mem",1,1,2,1, 1,3,0,0, 0,32'hDEAD,32'h11, 4'b0000,
                         1,32'h11, 1,32'hDEAD, 1,0));
        tbl.push_back(mk("lw_x4",     0,0,0,0, 1,4,1,0, 0,0,0, 4'b0000, 0,0,0,0, 1,0));
        tbl.push_back(mk("br_over_luh",4,1,0,0, 1,5,0,1, 0,0,0, 4'b0011, 0,0,0,0, 1,0));
        tbl.push_back(mk("post_br",   3,1,4,1, 0,0,0,0, 0,32'h44,32'h33, 4'b0000,
                         1,32'h33, 1,32'h44, 1,1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("wr_x0", 0,0,0,0, 1,0,0,0, 0,0,0, 4'b0000, 0,0,0,0, 1,1));
        tbl.push_back(mk("rd_x0",     0,1,0,1, 1,6,0,0, 1,2,3, 4'b0000, 0,0,0,0, 1,1));
        tbl.push_back(mk("alu_x6a",   0,0,0,0, 1,6,0,0, 0,0,0, 4'b0000, 0,0,0,0, 1,1));
        tbl.push_back(mk("alu_x6b",   0,0,0,0, 1,6,0,0, 0,0,0, 4'b0000, 0,0,0,0, 1,1));
        tbl.push_back(mk("prio_ex",   6,1,0,0, 0,0,0,1, 1,2,3, 4'b0011, 1,1,0,0, 1,1));
        tbl.push_back(mk("prio_mem",  6,1,0,0, 0,0,0,0, 1,2,3, 4'b0000, 1,2,0,0, 1,2));
        tbl.push_back(mk("prio_wb",   6,1,0,0, 0,0,0,0, 1,2,3, 4'b0000, 1,3,0,0, 1,2));
        tbl.push_back(mk("lw_x7",     0,0,0,0, 1,7,1,0, 0,0,0, 4'b0000, 0,0,0,0, 1,2));
        tbl.push_back(mk("lw_x8_luh", 7,1,0,0, 1,8,1,0, 0,0,0, 4'b1101, 0,0,0,0, 1,2));
        tbl.push_back(mk("lw_x8_fwd", 7,1,0,0, 1,8,1,0, 0,32'h77,0, 4'b0000,
                         1,32'h77, 0,0, 2,2));
        tbl.push_back(mk("add_luh",   0,0,8,1, 1,9,0,0, 0,0,0, 4'b1101, 0,0,0,0, 2,2));
        tbl.push_back(mk("add_fwd",   0,0,8,1, 1,9,0,0, 0,32'h88,0, 4'b0000,
                         0,0, 1,32'h88, 3,2));

        rst_n = 1'b1;
        ID_rs1 = '0; ID_rs2 = '0; ID_rs1_used = 1'b0; ID_rs2_used = 1'b0;
        ID_rf_we = 1'b0; ID_waddr = '0; ID_wb_sel = '0;
        EX_branch_taken = 1'b0;
        EX_alu_res = '0; MEM_wdata = '0; WB_wdata = '0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) run_vec(tbl[i]);

        run_vec(mk("lw_x10", 0,0,0,0, 1,10,1,0, 0,0,0, 4'b0000, 0,0,0,0, 3,2));
        run_vec(mk("luh_x10", 10,1,0,0, 1,11,0,0, 0,0,0, 4'b1101, 0,0,0,0, 3,2));
        #4;
        chk("stall_state", "fsm", 32'(dut.r_state), 32'(STALL));
        v = mk("rst_in_stall", 10,1,0,0, 1,11,0,0, 0,32'hAA,0, 4'b0000,
               1,32'hAA, 0,0, 4,2);
        v.rst = 1'b1;
        run_vec(v);
        run_vec(mk("post_rst", 10,1,0,0, 0,0,0,0, 0,32'hAA,32'hBB, 4'b0000,
                   0,0,0,0, 0,0));
        chk("post_rst", "fsm", 32'(dut.r_state), 32'(RUN));

        for (int i = 0; i < 256; i++)
            run_vec(mk("wrap", 0,0,0,0, 0,0,0,1, 0,0,0, 4'b0011,
                       0,0,0,0, 0,8'(i)));
        run_vec(mk("wrap_end", 0,0,0,0, 0,0,0,0, 0,0,0, 4'b0000, 0,0,0,0, 0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
